// File: rtl/pcie_pio_completer.sv
// PIO completer: single-DW MRd/MWr TLPs from the 7-series endpoint RX stream into a 32-bit register file, CplD on TX.
// Optional build macro PIO_UR_EN: unsupported MRd requests are drained and answered with a UR completion.
module pcie_pio_completer #(
    parameter int C_DATA_WIDTH   = 64,
    parameter int KEEP_WIDTH     = C_DATA_WIDTH / 8,
    parameter int REG_ADDR_WIDTH = 6
) (
    input  logic                      sys_clk,
    input  logic                      sys_reset_n,
    input  logic [C_DATA_WIDTH-1:0]   m_axis_rx_tdata,
    input  logic [KEEP_WIDTH-1:0]     m_axis_rx_tkeep,
    input  logic                      m_axis_rx_tlast,
    input  logic                      m_axis_rx_tvalid,
    input  logic [21:0]               m_axis_rx_tuser,
    output logic                      m_axis_rx_tready,
    output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]     s_axis_tx_tkeep,
    output logic                      s_axis_tx_tlast,
    output logic                      s_axis_tx_tvalid,
    output logic [3:0]                s_axis_tx_tuser,
    input  logic                      s_axis_tx_tready,
    input  logic [7:0]                cfg_bus_number,
    input  logic [4:0]                cfg_device_number,
    input  logic [2:0]                cfg_function_number,
    output logic                      cfg_trn_pending,
    output logic                      reg_wr_strobe,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr
);

    typedef enum logic [2:0] {RX_IDLE, RX_HDR, RX_DATA, RX_DRAIN, RX_WAIT} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_BEAT0, TX_BEAT1} tx_state_e;

    rx_state_e rx_state_q, rx_state_d;
    tx_state_e tx_state_q, tx_state_d;

    logic [31:0] regs_q [2**REG_ADDR_WIDTH];
    logic        rx_ready_q, pending_q, strobe_q;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, idx_q;
    logic        is_wr_q, is_64_q, poison_q, ur_q;
    logic [2:0]  tc_q;
    logic [1:0]  attr_q;
    logic [15:0] rid_q;
    logic [7:0]  tag_q;
    logic [3:0]  be_q;
    logic [4:0]  lo_addr_q;
    logic [31:0] rd_data_q;

    logic        rx_beat, hdr_ok, ur_req, wr_now, rd_now, tx_start, tx_done;
    logic [REG_ADDR_WIDTH-1:0] hdr_idx, wr_idx;
    logic [4:0]  hdr_lo;
    logic [31:0] wr_data, wr_swap;
    logic [11:0] byte_cnt;
    logic [1:0]  lo2;
    logic [31:0] cpl_dw0, cpl_dw1, cpl_dw2;
    logic        unused_ok;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign unused_ok = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:3], m_axis_rx_tuser[0]};

    assign rx_beat = m_axis_rx_tvalid && rx_ready_q;
    assign hdr_ok  = (m_axis_rx_tdata[28:24] == 5'd0) && (m_axis_rx_tdata[9:0] == 10'd1)
                     && m_axis_rx_tuser[2];
`ifdef PIO_UR_EN
    assign ur_req  = !m_axis_rx_tdata[30] && (m_axis_rx_tdata[28:24] == 5'd0) && !hdr_ok;
`else
    assign ur_req  = 1'b0;
`endif

    assign hdr_idx  = is_64_q ? m_axis_rx_tdata[REG_ADDR_WIDTH+33:34] : m_axis_rx_tdata[REG_ADDR_WIDTH+1:2];
    assign hdr_lo   = is_64_q ? m_axis_rx_tdata[38:34] : m_axis_rx_tdata[6:2];
    assign wr_now   = (rx_state_q == RX_HDR && rx_beat && is_wr_q && !is_64_q)
                      || (rx_state_q == RX_DATA && rx_beat);
    assign rd_now   = rx_state_q == RX_HDR && rx_beat && !is_wr_q;
    assign wr_data  = (rx_state_q == RX_DATA) ? m_axis_rx_tdata[31:0] : m_axis_rx_tdata[63:32];
    assign wr_idx   = (rx_state_q == RX_DATA) ? idx_q : hdr_idx;
    assign wr_swap  = bswap(wr_data);
    // Entering WAIT from any other state is the single trigger for both CplD and UR completions.
    assign tx_start = (rx_state_q != RX_WAIT) && (rx_state_d == RX_WAIT);
    assign tx_done  = (tx_state_q == TX_BEAT1) && s_axis_tx_tready;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_beat) begin
                          if (m_axis_rx_tlast) rx_state_d = ur_req ? RX_WAIT : RX_IDLE;
                          else                 rx_state_d = hdr_ok ? RX_HDR : RX_DRAIN;
                      end
            RX_HDR:   if (rx_beat) begin
                          if (!is_wr_q)             rx_state_d = RX_WAIT;
                          else if (m_axis_rx_tlast) rx_state_d = RX_IDLE;
                          else                      rx_state_d = is_64_q ? RX_DATA : RX_DRAIN;
                      end
            RX_DATA:  if (rx_beat) rx_state_d = m_axis_rx_tlast ? RX_IDLE : RX_DRAIN;
            RX_DRAIN: if (rx_beat && m_axis_rx_tlast) rx_state_d = ur_q ? RX_WAIT : RX_IDLE;
            RX_WAIT:  if (tx_done) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (tx_start) tx_state_d = TX_BEAT0;
            TX_BEAT0: if (s_axis_tx_tready) tx_state_d = TX_BEAT1;
            TX_BEAT1: if (s_axis_tx_tready) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int unsigned i = 0; i < 2**REG_ADDR_WIDTH; i++) regs_q[i] <= '0;
            rx_ready_q <= 1'b0;
            pending_q  <= 1'b0;
            strobe_q   <= 1'b0;
            wr_addr_q  <= '0;
            idx_q      <= '0;
            is_wr_q    <= 1'b0;
            is_64_q    <= 1'b0;
            poison_q   <= 1'b0;
            ur_q       <= 1'b0;
            tc_q       <= '0;
            attr_q     <= '0;
            rid_q      <= '0;
            tag_q      <= '0;
            be_q       <= '0;
            lo_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            rx_ready_q <= rx_state_d != RX_WAIT;
            strobe_q   <= wr_now && !poison_q;
            if (tx_start)     pending_q <= 1'b1;
            else if (tx_done) pending_q <= 1'b0;
            if (rx_state_q == RX_IDLE && rx_beat) begin
                is_wr_q  <= m_axis_rx_tdata[30];
                is_64_q  <= m_axis_rx_tdata[29];
                tc_q     <= m_axis_rx_tdata[22:20];
                attr_q   <= m_axis_rx_tdata[13:12];
                rid_q    <= m_axis_rx_tdata[63:48];
                tag_q    <= m_axis_rx_tdata[47:40];
                be_q     <= m_axis_rx_tdata[35:32];
                poison_q <= m_axis_rx_tuser[1];
                ur_q     <= ur_req;
            end
            if (rx_state_q == RX_HDR && rx_beat) begin
                idx_q     <= hdr_idx;
                lo_addr_q <= hdr_lo;
            end
            if (rd_now) rd_data_q <= bswap(regs_q[hdr_idx]);
            if (wr_now && !poison_q) begin
                wr_addr_q <= wr_idx;
                for (int unsigned b = 0; b < 4; b++)
                    if (be_q[b]) regs_q[wr_idx][8*b +: 8] <= wr_swap[8*b +: 8];
            end
        end
    end

    always_comb begin
        byte_cnt = 12'd1;
        casez (be_q)
            4'b1??1:                   byte_cnt = 12'd4;
            4'b01?1, 4'b1?10:          byte_cnt = 12'd3;
            4'b0011, 4'b0110, 4'b1100: byte_cnt = 12'd2;
            default:                   byte_cnt = 12'd1;
        endcase
        casez (be_q)
            4'b???1: lo2 = 2'b00;
            4'b??10: lo2 = 2'b01;
            4'b?100: lo2 = 2'b10;
            4'b1000: lo2 = 2'b11;
            default: lo2 = 2'b00;
        endcase
    end

    always_comb begin
        if (ur_q) begin
            cpl_dw0 = {1'b0, 2'b00, 5'b01010, 1'b0, tc_q, 6'd0, attr_q, 2'd0, 10'd0};
            cpl_dw1 = {cfg_bus_number, cfg_device_number, cfg_function_number, 3'b001, 1'b0, 12'd4};
            cpl_dw2 = {rid_q, tag_q, 8'd0};
        end else begin
            cpl_dw0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc_q, 6'd0, attr_q, 2'd0, 10'd1};
            cpl_dw1 = {cfg_bus_number, cfg_device_number, cfg_function_number, 3'b000, 1'b0, byte_cnt};
            cpl_dw2 = {rid_q, tag_q, 1'b0, lo_addr_q, lo2};
        end
    end

    always_comb begin
        s_axis_tx_tvalid = 1'b0;
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tdata  = '0;
        case (tx_state_q)
            TX_BEAT0: begin
                s_axis_tx_tvalid = 1'b1;
                s_axis_tx_tkeep  = 8'hFF;
                s_axis_tx_tdata  = {cpl_dw1, cpl_dw0};
            end
            TX_BEAT1: begin
                s_axis_tx_tvalid = 1'b1;
                s_axis_tx_tlast  = 1'b1;
                s_axis_tx_tkeep  = ur_q ? 8'h0F : 8'hFF;
                s_axis_tx_tdata  = ur_q ? {32'd0, cpl_dw2} : {rd_data_q, cpl_dw2};
            end
            default: ;
        endcase
    end

    assign s_axis_tx_tuser  = '0;
    assign m_axis_rx_tready = rx_ready_q;
    assign cfg_trn_pending  = pending_q;
    assign reg_wr_strobe    = strobe_q;
    assign reg_wr_addr      = wr_addr_q;

endmodule

// File: tb/tb_pcie_pio_completer.sv
// Scoreboard bench for pcie_pio_completer: expected TX beats queued at stimulus time, compared as they leave the DUT.
module tb_pcie_pio_completer;

    localparam logic [7:0] BUS  = 8'h12;
    localparam logic [4:0] DEV  = 5'h03;
    localparam logic [2:0] FUNC = 3'h1;
    localparam logic [21:0] TU_BAR = 22'h4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] rx_tdata = '0;
    logic [7:0]  rx_tkeep = '0;
    logic        rx_tlast = 1'b0, rx_tvalid = 1'b0;
    logic [21:0] rx_tuser = '0;
    logic        rx_tready;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tlast, tx_tvalid;
    logic [3:0]  tx_tuser;
    logic        tx_tready = 1'b1;
    logic        pending, wr_strobe;
    logic [5:0]  wr_addr;

    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
    beat_t       exp_q[$];
    logic [31:0] model [64];
    int unsigned n_chk = 0, n_fail = 0;
    int unsigned strobes_seen = 0, strobes_exp = 0, unexpected_tx = 0, rx_timeouts = 0;

    always #5 clk = ~clk;

    pcie_pio_completer #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8), .REG_ADDR_WIDTH(6)) dut (
        .sys_clk(clk), .sys_reset_n(rst_n),
        .m_axis_rx_tdata(rx_tdata), .m_axis_rx_tkeep(rx_tkeep), .m_axis_rx_tlast(rx_tlast),
        .m_axis_rx_tvalid(rx_tvalid), .m_axis_rx_tuser(rx_tuser), .m_axis_rx_tready(rx_tready),
        .s_axis_tx_tdata(tx_tdata), .s_axis_tx_tkeep(tx_tkeep), .s_axis_tx_tlast(tx_tlast),
        .s_axis_tx_tvalid(tx_tvalid), .s_axis_tx_tuser(tx_tuser), .s_axis_tx_tready(tx_tready),
        .cfg_bus_number(BUS), .cfg_device_number(DEV), .cfg_function_number(FUNC),
        .cfg_trn_pending(pending), .reg_wr_strobe(wr_strobe), .reg_wr_addr(wr_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bsw(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Byte count as span from lowest to highest enabled byte; lo2 is the lowest enabled byte.
    function automatic int lowest_be(input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) return i;
        return -1;
    endfunction

    function automatic int highest_be(input logic [3:0] be);
        for (int i = 3; i >= 0; i--) if (be[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_strobe) strobes_seen++;
            if (tx_tvalid && tx_tready) begin
                if (exp_q.size() == 0) unexpected_tx++;
                else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("tx_data", tx_tdata, b.data);
                    chk("tx_keep", {56'd0, tx_tkeep}, {56'd0, b.keep});
                    chk("tx_last", {63'd0, tx_tlast}, {63'd0, b.last});
                end
            end else if (tx_tvalid && exp_q.size() != 0) begin
                chk("tx_hold", tx_tdata, exp_q[0].data);
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic last, input logic [21:0] tu);
        int unsigned n;
        n = 0;
        rx_tdata = d; rx_tlast = last; rx_tuser = tu; rx_tkeep = 8'hFF; rx_tvalid = 1'b1;
        @(negedge clk);
        while (!rx_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rx_tready) rx_timeouts++;
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic mwr(input logic [63:0] addr, input bit is64, input logic [3:0] be,
                       input logic [31:0] pl, input logic [21:0] tu, input bit commit);
        logic [31:0] dw0, dw1, sw;
        logic [5:0]  idx;
        dw0 = {1'b0, is64 ? 2'b11 : 2'b10, 5'd0, 1'b0, 3'd0, 6'd0, 2'd0, 2'd0, 10'd1};
        dw1 = {16'hBEEF, 8'h00, 4'h0, be};
        idx = addr[7:2];
        send_beat({dw1, dw0}, 1'b0, tu);
        if (is64) begin
            send_beat({addr[31:0], addr[63:32]}, 1'b0, tu);
            send_beat({32'd0, pl}, 1'b1, tu);
        end else begin
            send_beat({pl, addr[31:0]}, 1'b1, tu);
        end
        chk("wr_strobe", {63'd0, wr_strobe}, {63'd0, commit});
        if (commit) begin
            chk("wr_addr", {58'd0, wr_addr}, {58'd0, idx});
            strobes_exp++;
            sw = bsw(pl);
            for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = sw[8*b +: 8];
        end
    endtask

    // mode 0: no response, 1: CplD, 2: UR completion
    task automatic mrd(input logic [63:0] addr, input bit is64, input logic [3:0] be, input logic [7:0] tag,
                       input logic [2:0] tc, input logic [1:0] attr, input logic [9:0] len,
                       input logic [21:0] tu, input int mode);
        logic [31:0] dw0, dw1, c0, c1, c2;
        int lo, hi;
        beat_t b;
        dw0 = {1'b0, is64 ? 2'b01 : 2'b00, 5'd0, 1'b0, tc, 6'd0, attr, 2'd0, len};
        dw1 = {16'hBEEF, tag, 4'h0, be};
        lo = lowest_be(be);
        hi = highest_be(be);
        if (mode == 1) begin
            c0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc, 6'd0, attr, 2'd0, 10'd1};
            c1 = {BUS, DEV, FUNC, 3'b000, 1'b0, (lo < 0) ? 12'd1 : 12'(hi - lo + 1)};
            c2 = {16'hBEEF, tag, 1'b0, addr[6:2], (lo < 0) ? 2'd0 : 2'(lo)};
            b.data = {c1, c0}; b.keep = 8'hFF; b.last = 1'b0; exp_q.push_back(b);
            b.data = {bsw(model[addr[7:2]]), c2}; b.keep = 8'hFF; b.last = 1'b1; exp_q.push_back(b);
        end else if (mode == 2) begin
            c0 = {1'b0, 2'b00, 5'b01010, 1'b0, tc, 6'd0, attr, 2'd0, 10'd0};
            c1 = {BUS, DEV, FUNC, 3'b001, 1'b0, 12'd4};
            c2 = {16'hBEEF, tag, 8'd0};
            b.data = {c1, c0}; b.keep = 8'hFF; b.last = 1'b0; exp_q.push_back(b);
            b.data = {32'd0, c2}; b.keep = 8'h0F; b.last = 1'b1; exp_q.push_back(b);
        end
        send_beat({dw1, dw0}, 1'b0, tu);
        if (is64) send_beat({addr[31:0], addr[63:32]}, 1'b1, tu);
        else      send_beat({32'd0, addr[31:0]}, 1'b1, tu);
        if (mode != 0) begin
            chk("cpl_valid", {63'd0, tx_tvalid}, 64'd1);
            chk("pending_set", {63'd0, pending}, 64'd1);
            chk("rx_ready_wait", {63'd0, rx_tready}, 64'd0);
        end else begin
            chk("no_pending", {63'd0, pending}, 64'd0);
            chk("no_cpl", {63'd0, tx_tvalid}, 64'd0);
        end
    endtask

    task automatic wait_tx();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("tx_drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("pending_clr", {63'd0, pending}, 64'd0);
        chk("rx_ready_back", {63'd0, rx_tready}, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = '0;
        #22;
        chk("rst_rx_ready", {63'd0, rx_tready}, 64'd0);
        chk("rst_tx_valid", {63'd0, tx_tvalid}, 64'd0);
        chk("rst_pending", {63'd0, pending}, 64'd0);
        chk("rst_strobe", {63'd0, wr_strobe}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rx_ready_up", {63'd0, rx_tready}, 64'd1);

        mwr(64'h10, 1'b0, 4'hF, 32'h78563412, TU_BAR, 1'b1);
        chk("wr_addr_4", {58'd0, wr_addr}, 64'd4);
        mrd(64'h10, 1'b0, 4'hF, 8'h2A, 3'd0, 2'd0, 10'd1, TU_BAR, 1);
        chk("cpl_dw0_const", {32'd0, tx_tdata[31:0]}, 64'h4A000001);
        wait_tx();

        mwr(64'h08, 1'b0, 4'hF, 32'hDDCCBBAA, TU_BAR, 1'b1);
        mwr(64'h1_0000_0008, 1'b1, 4'h3, 32'h11223344, TU_BAR, 1'b1);
        mrd(64'h1_0000_0008, 1'b1, 4'hF, 8'h05, 3'd3, 2'd2, 10'd1, TU_BAR, 1);
        wait_tx();

        mwr(64'h24, 1'b0, 4'hF, 32'hCAFEF00D, TU_BAR, 1'b1);
        tx_tready = 1'b0;
        mrd(64'h24, 1'b0, 4'h8, 8'h11, 3'd0, 2'd0, 10'd1, TU_BAR, 1);
        repeat (5) begin
            @(negedge clk);
            chk("rx_ready_hold", {63'd0, rx_tready}, 64'd0);
        end
        @(posedge clk); #1;
        tx_tready = 1'b1;
        wait_tx();

`ifdef PIO_UR_EN
        mrd(64'h10, 1'b0, 4'hF, 8'h33, 3'd1, 2'd0, 10'd2, TU_BAR, 2);
        wait_tx();
`else
        mrd(64'h10, 1'b0, 4'hF, 8'h33, 3'd1, 2'd0, 10'd2, TU_BAR, 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
`endif
        mwr(64'h30, 1'b0, 4'h6, 32'h01020304, TU_BAR, 1'b1);
        mrd(64'h30, 1'b0, 4'h6, 8'h44, 3'd0, 2'd1, 10'd1, TU_BAR, 1);
        wait_tx();

        mwr(64'h10, 1'b0, 4'hF, 32'hFFFFFFFF, TU_BAR | 22'h2, 1'b0);
        mwr(64'h10, 1'b0, 4'hF, 32'hEEEEEEEE, 22'h0, 1'b0);
        mrd(64'h10, 1'b0, 4'hF, 8'h55, 3'd0, 2'd0, 10'd1, TU_BAR, 1);
        chk("tx_tuser", {60'd0, tx_tuser}, 64'd0);
        wait_tx();

        tx_tready = 1'b0;
        mrd(64'h10, 1'b0, 4'hF, 8'h66, 3'd0, 2'd0, 10'd1, TU_BAR, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {63'd0, tx_tvalid}, 64'd0);
        chk("rst_async_pending", {63'd0, pending}, 64'd0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) model[i] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_tready = 1'b1;
        @(posedge clk); #1;
        chk("rx_ready_after_rst", {63'd0, rx_tready}, 64'd1);
        mrd(64'h10, 1'b0, 4'hF, 8'h77, 3'd0, 2'd0, 10'd1, TU_BAR, 1);
        wait_tx();

        repeat (3) @(negedge clk);
        chk("strobe_count", 64'(strobes_seen), 64'(strobes_exp));
        chk("unexpected_tx", 64'(unexpected_tx), 64'd0);
        chk("rx_timeouts", 64'(rx_timeouts), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
